mem_responder: RTL and testbench

- Memory-side responder for the multi-cycle core's data/instruction port.
- Services the core's memread/memwrite strobes, which are held until the responder pulses ready.
- Accesses below IO_BASE go to an external synchronous single-port RAM; accesses at or above IO_BASE go to a small internal MMIO register block (GPIO, timer, status).
- Sits between the control state machine/datapath and the RAM macro.

---
 rtl/mem_responder.sv | 133 +++++++++++++
 tb/tb_mem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: serves held memread/memwrite strobes from either an external
// synchronous single-port RAM or a small internal MMIO block (GPIO, timer, status).
module mem_responder #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [15:0] IO_BASE     = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        ram_en,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, RAM_ACC, RAM_WAIT, IO_ACC, RESP} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [15:0] timer;
    logic        op_write;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] io_off;

    assign io_off = addr_q - IO_BASE;

    // Request latches carry data only, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && (memread || memwrite)) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            op_write <= memwrite;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            timer     <= 16'd0;
            rdata     <= 16'd0;
            ready     <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= 16'd0;
            ram_wdata <= 16'd0;
            gpio_out  <= 16'd0;
            err       <= 1'b0;
        end else begin
            timer <= timer + 16'd1;
            case (state)
                IDLE: begin
                    if (memread || memwrite) begin
                        // Both strobes together resolve to a write and flag the protocol error.
                        if (memread && memwrite)
                            err <= 1'b1;
                        if (addr < IO_BASE) begin
                            state     <= RAM_ACC;
                            ram_en    <= 1'b1;
                            ram_we    <= memwrite;
                            ram_addr  <= addr;
                            ram_wdata <= wdata;
                        end else begin
                            state <= IO_ACC;
                        end
                    end
                end
                RAM_ACC: begin
                    ram_en   <= 1'b0;
                    ram_we   <= 1'b0;
                    wait_cnt <= 4'd0;
                    state    <= RAM_WAIT;
                end
                RAM_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        if (!op_write)
                            rdata <= ram_rdata;
                        ready <= 1'b1;
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                IO_ACC: begin
                    case (io_off)
                        16'd0: begin
                            if (op_write) gpio_out <= wdata_q;
                            else          rdata    <= gpio_out;
                        end
                        16'd1: begin
                            if (!op_write) rdata <= gpio_in;
                        end
                        16'd2: begin
                            // A timer write overrides this edge's increment.
                            if (op_write) timer <= wdata_q;
                            else          rdata <= timer;
                        end
                        16'd3: begin
                            if (op_write) begin
                                if (wdata_q[0]) err <= 1'b0;
                            end else begin
                                rdata <= {15'b0, err};
                            end
                        end
                        default: begin
                            if (!op_write) rdata <= 16'd0;
                        end
                    endcase
                    ready <= 1'b1;
                    state <= RESP;
                end
                RESP: begin
                    ready <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: transaction-level reference model plus a
// per-cycle compare process and a few literal scenario checks.
module tb_mem_responder;

    localparam int          WS  = 3;
    localparam logic [15:0] IOB = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [15:0] addr = 16'd0;
    logic [15:0] wdata = 16'd0;
    logic [15:0] gpio_in = 16'd0;
    logic [15:0] rdata, ram_addr, ram_wdata, ram_rdata, gpio_out;
    logic        ready, ram_en, ram_we, err;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_STATES(WS), .IO_BASE(IOB)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .gpio_in(gpio_in), .gpio_out(gpio_out), .err(err)
    );

    // External synchronous RAM: output register holds until the next enabled read.
    logic [15:0] ram_mem [0:63];
    logic [15:0] ram_q = 16'd0;
    int          we_cnt = 0;
    assign ram_rdata = ram_q;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr[5:0]] <= ram_wdata;
            else        ram_q <= ram_mem[ram_addr[5:0]];
            if (ram_we) we_cnt <= we_cnt + 1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one outstanding transaction with a countdown to its response edge.
    logic [15:0] m_mem [0:63];
    bit          m_busy = 0, m_ready = 0, m_write = 0, m_io = 0;
    int          m_left = 0;
    logic [15:0] m_addr = 0, m_wdata = 0, m_rdata = 0, m_gpio = 0, m_timer = 0, t_now;
    logic        m_err = 0, m_ram_en = 0, m_ram_we = 0;
    logic [15:0] m_ram_addr = 0, m_ram_wdata = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_ready = 0; m_left = 0;
            m_rdata = 0; m_gpio = 0; m_timer = 0; m_err = 0; m_ram_en = 0;
        end else begin
            t_now   = m_timer;
            m_timer = m_timer + 16'd1;
            m_ram_en = 0;
            if (m_ready) begin
                m_ready = 0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy  = 0;
                    m_ready = 1;
                    if (!m_io) begin
                        if (!m_write) m_rdata = m_mem[m_addr[5:0]];
                    end else begin
                        case (m_addr - IOB)
                            16'd0: if (m_write) m_gpio = m_wdata; else m_rdata = m_gpio;
                            16'd1: if (!m_write) m_rdata = gpio_in;
                            16'd2: if (m_write) m_timer = m_wdata; else m_rdata = t_now;
                            16'd3: if (m_write) begin if (m_wdata[0]) m_err = 0; end
                                   else m_rdata = {15'b0, m_err};
                            default: if (!m_write) m_rdata = 16'd0;
                        endcase
                    end
                end
            end else if (memread || memwrite) begin
                m_busy  = 1;
                m_write = memwrite;
                m_addr  = addr;
                m_wdata = wdata;
                m_io    = (addr >= IOB);
                if (memread && memwrite) m_err = 1;
                m_left  = m_io ? 1 : 2 + WS;
                if (!m_io) begin
                    m_ram_en = 1; m_ram_we = memwrite; m_ram_addr = addr; m_ram_wdata = wdata;
                    if (memwrite) m_mem[addr[5:0]] = wdata;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ready", 16'(ready), 16'(m_ready));
            chk("rdata", rdata, m_rdata);
            chk("gpio_out", gpio_out, m_gpio);
            chk("err", 16'(err), 16'(m_err));
            chk("ram_en", 16'(ram_en), 16'(m_ram_en));
            if (m_ram_en) begin
                chk("ram_we", 16'(ram_we), 16'(m_ram_we));
                chk("ram_addr", ram_addr, m_ram_addr);
                if (m_ram_we) chk("ram_wdata", ram_wdata, m_ram_wdata);
            end
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input bit early,
                          output logic [15:0] r, output int lat);
        bit got;
        got = 0; r = 16'd0; lat = -1;
        memread = rd; memwrite = wr; addr = a; wdata = d;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            lat++;
            if (early && lat == 0) begin memread = 1'b0; memwrite = 1'b0; end
            if (ready) begin r = rdata; got = 1; break; end
        end
        memread = 1'b0; memwrite = 1'b0;
        chk("req_done", 16'(got), 16'd1);
        @(posedge clk); #1;
        chk("ready_width", 16'(ready), 16'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rv, a, d;
        int          lat, we0;
        bit          io, rd, wr, early;
        int          kind;

        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = 16'(i * 16'h1111) ^ 16'h5A5A;
            m_mem[i]   = 16'(i * 16'h1111) ^ 16'h5A5A;
        end
        ram_mem[5] = 16'hBEEF;
        m_mem[5]   = 16'hBEEF;

        reset = 1'b0;
        idle(3);
        chk_on = 1'b1;
        chk("rst_ready", 16'(ready), 16'd0);
        chk("rst_rdata", rdata, 16'd0);
        chk("rst_ram_en", 16'(ram_en), 16'd0);
        chk("rst_ram_addr", ram_addr, 16'd0);
        chk("rst_gpio", gpio_out, 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        reset = 1'b1;
        idle(2);

        we0 = we_cnt;
        do_req(1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0, rv, lat);
        chk("ram_w_lat", 16'(lat), 16'd5);
        chk("ram_we_pulses", 16'(we_cnt - we0), 16'd1);
        chk("ram_w_content", ram_mem[16], 16'h1234);
        do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, rv, lat);
        chk("ram_r_lat", 16'(lat), 16'd5);
        chk("ram_r_data", rv, 16'h1234);
        do_req(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, rv, lat);
        chk("beef_data", rv, 16'hBEEF);

        do_req(1'b0, 1'b1, 16'hFF00, 16'hA5A5, 1'b0, rv, lat);
        chk("io_lat", 16'(lat), 16'd1);
        chk("gpio_wr", gpio_out, 16'hA5A5);
        gpio_in = 16'h00F0;
        do_req(1'b1, 1'b0, 16'hFF01, 16'h0000, 1'b0, rv, lat);
        chk("gpio_in_rd", rv, 16'h00F0);
        do_req(1'b0, 1'b1, 16'hFF01, 16'h1111, 1'b0, rv, lat);
        chk("gpio_in_wr_ignored", gpio_out, 16'hA5A5);

        do_req(1'b0, 1'b1, 16'hFF02, 16'hFFFE, 1'b0, rv, lat);
        idle(2);
        do_req(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0, rv, lat);
        chk("timer_wrap", rv, 16'h0002);

        do_req(1'b1, 1'b1, 16'h0020, 16'h7777, 1'b0, rv, lat);
        chk("both_err", 16'(err), 16'd1);
        chk("both_ram_write", ram_mem[32], 16'h7777);
        do_req(1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b0, rv, lat);
        chk("status_rd", rv, 16'h0001);
        do_req(1'b0, 1'b1, 16'hFF03, 16'h0001, 1'b0, rv, lat);
        chk("status_clr", 16'(err), 16'd0);

        // Abort a RAM read in its wait phase with an asynchronous reset.
        do_req(1'b1, 1'b1, 16'h0021, 16'h4242, 1'b0, rv, lat);
        chk("pre_rst_err", 16'(err), 16'd1);
        memread = 1'b1; addr = 16'h0005;
        idle(3);
        memread = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("midrst_ready", 16'(ready), 16'd0);
        chk("midrst_ram_en", 16'(ram_en), 16'd0);
        chk("midrst_err", 16'(err), 16'd0);
        idle(2);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("post_rst_no_ready", 16'(ready), 16'd0);
        end

        for (int t = 0; t < 250; t++) begin
            io    = ($urandom_range(0, 2) == 0);
            a     = io ? 16'(IOB + 16'($urandom_range(0, 5))) : 16'($urandom_range(0, 63));
            kind  = $urandom_range(0, 9);
            rd    = (kind < 5) || (kind == 9);
            wr    = (kind >= 5);
            d     = 16'($urandom);
            early = ($urandom_range(0, 3) == 0);
            gpio_in = 16'($urandom);
            do_req(rd, wr, a, d, early, rv, lat);
            chk("rand_lat", 16'(lat), io ? 16'd1 : 16'(2 + WS));
            idle($urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
